// File: rtl/vfir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vfir_pkg
// Purpose  : Shared types and constants for the vector FIR sequencer:
//            SIMD ALU geometry, ALU opcodes and the controller state enum.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vfir_pkg;

  // SIMD ALU geometry: 16 lanes of 16 bits.
  localparam int LANES = 16;
  localparam int LW    = 16;

  // ALU opcodes understood by the shared vector ALU.
  localparam logic [2:0] VADD = 3'b000;
  localparam logic [2:0] VSUB = 3'b001;
  localparam logic [2:0] VMUL = 3'b011;
  localparam logic [2:0] VROT = 3'b101;

  // Sequencer states; each tap walks FETCH -> MUL -> ACC -> ROT.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MUL   = 3'd2,
    ST_ACC   = 3'd3,
    ST_ROT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage : vfir_pkg
`default_nettype wire

// File: rtl/vfir_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vfir_sequencer
// Purpose  : Multi-cycle controller computing one vector FIR output step on
//            the shared 256-bit SIMD ALU. Per tap: fetch coefficient vector,
//            multiply with the sample window, accumulate, rotate the window
//            by one lane.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            i_start/i_ntaps/     - run request, tap count (clamped to
//            i_window               MAXTAPS) and sample window
//            o_coeff_rd/addr,     - coefficient memory read port (data one
//            i_coeff_data           cycle after the strobe)
//            o_alu_a/b/ctrl/      - ALU operand/opcode drive, valid while
//            o_alu_regsel,          busy; combinational result returns on
//            i_alu_result           i_alu_result
//            o_busy/o_done        - run in progress / completion pulse
//            o_result             - accumulator
// Revision : 1.0 - initial release
// ============================================================================
module vfir_sequencer #(
  parameter int LANES   = 16,
  parameter int LW      = 16,
  parameter int MAXTAPS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [$clog2(MAXTAPS):0]   i_ntaps,
  input  logic [LANES*LW-1:0]        i_window,
  output logic                       o_coeff_rd,
  output logic [$clog2(MAXTAPS)-1:0] o_coeff_addr,
  input  logic [LANES*LW-1:0]        i_coeff_data,
  output logic [LANES*LW-1:0]        o_alu_a,
  output logic [LANES*LW-1:0]        o_alu_b,
  output logic [2:0]                 o_alu_ctrl,
  output logic                       o_alu_regsel,
  input  logic [LANES*LW-1:0]        i_alu_result,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [LANES*LW-1:0]        o_result
);

  import vfir_pkg::*;

  localparam int VW = LANES * LW;
  localparam int AW = $clog2(MAXTAPS);
  localparam int NW = AW + 1;

  state_t          r_state;
  state_t          w_next;
  logic [NW-1:0]   r_ntaps;
  logic [NW-1:0]   r_k;
  logic [VW-1:0]   r_win;
  logic [VW-1:0]   r_prod;
  logic [VW-1:0]   r_acc;
  logic [NW-1:0]   w_ntaps_clamped;
  logic            w_last_tap;

  assign w_ntaps_clamped = (i_ntaps > NW'(MAXTAPS)) ? NW'(MAXTAPS) : i_ntaps;
  // r_k still holds the index of the tap being finished while in ROT.
  assign w_last_tap      = ((r_k + NW'(1)) == r_ntaps);
  assign o_result        = r_acc;

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ntaps <= '0;
      r_k     <= '0;
      r_win   <= '0;
      r_prod  <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_ntaps <= w_ntaps_clamped;
            r_win   <= i_window;
            r_acc   <= '0;
            r_k     <= '0;
          end
        end
        ST_MUL:  r_prod <= i_alu_result;
        ST_ACC:  r_acc  <= i_alu_result;
        ST_ROT: begin
          r_win <= i_alu_result;
          r_k   <= r_k + NW'(1);
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_coeff_rd   = 1'b0;
    o_coeff_addr = '0;
    o_alu_a      = '0;
    o_alu_b      = '0;
    o_alu_ctrl   = VADD;
    o_alu_regsel = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next = (w_ntaps_clamped == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_busy       = 1'b1;
        o_coeff_rd   = 1'b1;
        o_coeff_addr = r_k[AW-1:0];
        w_next       = ST_MUL;
      end
      ST_MUL: begin
        // Coefficient data returns this cycle, one after the read strobe.
        o_busy       = 1'b1;
        o_alu_ctrl   = VMUL;
        o_alu_regsel = 1'b1;
        o_alu_a      = r_win;
        o_alu_b      = i_coeff_data;
        w_next       = ST_ACC;
      end
      ST_ACC: begin
        o_busy       = 1'b1;
        o_alu_ctrl   = VADD;
        o_alu_regsel = 1'b1;
        o_alu_a      = r_acc;
        o_alu_b      = r_prod;
        w_next       = ST_ROT;
      end
      ST_ROT: begin
        o_busy       = 1'b1;
        o_alu_ctrl   = VROT;
        o_alu_regsel = 1'b1;
        o_alu_a      = r_win;
        w_next       = w_last_tap ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule : vfir_sequencer
`default_nettype wire

// File: doc/vfir_sequencer.md
# vfir_sequencer

Multi-cycle controller that runs one vector FIR output step on the shared 256-bit SIMD ALU (16 lanes × 16 bit). The block latches a sample window and fetches one coefficient vector per tap from coefficient memory. For each tap it issues vector multiply, vector accumulate and a one-lane window rotate to the ALU, then presents the 256-bit accumulated result. It sits between the core's vector issue logic and the ALU operand muxes, and drives them whenever `busy` is high.

## Interface
- `LANES`, 16, number of lanes; fixed by the ALU.
- `LW`, 16, lane width in bits.
- `MAXTAPS`, 16, maximum tap count; `coeff_addr` width is log2(MAXTAPS).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `ntaps`  in  5  tap count, 0..16; latched with `start`.
- `window`  in  256  sample window, lane i = bits [16i+15:16i]; latched with `start`.
- `coeff_rd`  out  1  coefficient read strobe.
- `coeff_addr`  out  4  tap index k.
- `coeff_data`  in  256  coefficient vector; valid the cycle after `coeff_rd`.
- `alu_a`, `alu_b`  out  256  ALU operands.
- `alu_ctrl`  out  3  ALU opcode.
- `alu_regsel`  out  1  1 = vector mode.
- `alu_result`  in  256  combinational ALU result, same cycle.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  256  accumulator.

## Operation
- States: IDLE, FETCH, MUL, ACC, ROT, DONE.
- IDLE:
  - On `start`, latch `ntaps` and `window`; clear acc and k.
  - If `ntaps` = 0, go to DONE. Otherwise go to FETCH.
- FETCH: `coeff_rd`=1, `coeff_addr`=k → MUL.
- MUL:
  - ALU: ctrl=011, regsel=1, A=win, B=`coeff_data`.
  - Register `alu_result` into prod → ACC.
- ACC:
  - ALU: ctrl=000, regsel=1, A=acc, B=prod.
  - Register `alu_result` into acc → ROT.
- ROT:
  - ALU: ctrl=101, regsel=1, A=win, B=0.
  - Register `alu_result` into win. The rotate moves lane i to lane i+1 and lane 15 to lane 0.
  - Then k++. If k+1 = ntaps, go to DONE; else go to FETCH.
- DONE: `done`=1 → IDLE.
- Arithmetic is lane-wise modulo 2^16, set by ALU truncation. Overflow is not detected, and ALU flags are ignored.
- Outside MUL/ACC/ROT: `alu_a`=`alu_b`=0, `alu_ctrl`=000, `alu_regsel`=0.
- `start` is ignored in every state except IDLE, including a `start` in DONE.
- `ntaps` values greater than 16 are clamped to 16.
- `result` equals acc at all times. It is stable from `done` until the next accepted `start`, and clears the cycle after that `start`.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `coeff_rd` = 0; `coeff_addr`=0; `result`=0; ALU outputs at the idle values above.
- `rst` has priority over all other inputs. Asserting it mid-run aborts immediately: no `done` pulse, and acc is cleared.
- If `start` is accepted in cycle T:
  - `busy`=1 from T+1 through T+4n.
  - `done`=1 in cycle T+1+4n, with `busy`=0 in that cycle.
- With n = 0, `done` is asserted at T+1.
- Each tap takes exactly 4 cycles; there are no stalls.
- Earliest restart: `start` sampled in the cycle after DONE.

## Structure
- Package `vfir_pkg` holds:
  - the state enum;
  - the ALU opcode constants VADD=3'b000, VSUB=3'b001, VMUL=3'b011, VROT=3'b101;
  - `LANES` and `LW`.
- Single module; no sub-modules. The ALU is instantiated by the parent, not inside this block.

## Test plan
- Uniform case: all `window` lanes 2, coefficient k all lanes k+1, ntaps=3.
  - Expect every result lane = 12.
  - Expect `done` at T+13.
  - Expect `coeff_addr` sequence 0, 1, 2.
- Rotation case: window lane i = i, all coefficients 1, ntaps=2.
  - Expect result lane 0 = 15, lane 1 = 1, lane 5 = 9, lane 15 = 29.
- Wrap and zero taps:
  - Window 0x8000 in all lanes, coefficients 2, ntaps=1: expect all lanes 0x0000.
  - ntaps=0: expect `done` at T+1 and result 0.
- Reset mid-run: ntaps=16, `rst` asserted at T+20.
  - Expect IDLE and all outputs at reset values next cycle, and no `done` pulse.
  - A following run produces the correct result.
- Ignored start: `start` held high throughout a run with ntaps=4.
  - Expect one `done` at T+17.
  - Next `start` accepted at T+18; result unchanged until then.
